// File: rtl/ccm_matrix_pkg.sv
// Shared register map and reset defaults for the colour-correction matrix.
// Coefficients occupy 0..8, offsets 9..11, and the control word sits at 12.
package ccm_matrix_pkg;

   localparam int COEF_BASE = 0;
   localparam int OFFS_BASE = 9;
   localparam int CTRL_ADDR = 12;
   localparam int NUM_CM    = 12;

   // Identity matrix: unity on the diagonal (c0, c4, c8), zero elsewhere.
   function automatic int ident_value(input int idx, input int frac);
      if (idx == COEF_BASE + 0 || idx == COEF_BASE + 4 || idx == COEF_BASE + 8)
         return 1 << frac;
      return 0;
   endfunction

endpackage

// File: rtl/ccm_matrix_row.sv
// One output channel of the matrix: three products, then offset and rounding,
// then shift and clamp. The bypass pixel follows the same three registers.
module ccm_row
   import ccm_matrix_pkg::*;
#(
   parameter int DW   = 8,
   parameter int CW   = 12,
   parameter int FRAC = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DW-1:0]        r_i,
   input  logic [DW-1:0]        g_i,
   input  logic [DW-1:0]        b_i,
   input  logic signed [CW-1:0] k0_i,
   input  logic signed [CW-1:0] k1_i,
   input  logic signed [CW-1:0] k2_i,
   input  logic signed [CW-1:0] off_i,
   input  logic                 bypass_i,
   input  logic [DW-1:0]        self_i,
   output logic [DW-1:0]        pix_o
);

   localparam int PW = DW + CW + 1;
   localparam int IW = DW + CW + 3;
   localparam logic signed [IW-1:0] RND  = IW'(1) <<< (FRAC - 1);
   localparam logic signed [IW-1:0] MAXV = {{(IW-DW){1'b0}}, {DW{1'b1}}};

   function automatic logic signed [PW-1:0] mul(input logic [DW-1:0] pix,
                                                input logic signed [CW-1:0] coef);
      logic signed [PW-1:0] a;
      logic signed [PW-1:0] b;
      a = PW'($signed({1'b0, pix}));
      b = PW'(coef);
      return a * b;
   endfunction

   function automatic logic [DW-1:0] shift_clamp(input logic signed [IW-1:0] s);
      logic signed [IW-1:0] t;
      t = s >>> FRAC;
      if (t < 0)
         return '0;
      if (t > MAXV)
         return {DW{1'b1}};
      return t[DW-1:0];
   endfunction

   logic signed [PW-1:0] prod0_p1_q, prod1_p1_q, prod2_p1_q;
   logic signed [CW-1:0] off_p1_q;
   logic                 byp_p1_q, byp_p2_q;
   logic [DW-1:0]        self_p1_q, self_p2_q;
   logic signed [IW-1:0] sum_p2_q;
   logic [DW-1:0]        pix_p3_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         prod0_p1_q <= '0;
         prod1_p1_q <= '0;
         prod2_p1_q <= '0;
         off_p1_q   <= '0;
         byp_p1_q   <= 1'b0;
         self_p1_q  <= '0;
         sum_p2_q   <= '0;
         byp_p2_q   <= 1'b0;
         self_p2_q  <= '0;
         pix_p3_q   <= '0;
      end else begin
         // p1: products
         prod0_p1_q <= mul(r_i, k0_i);
         prod1_p1_q <= mul(g_i, k1_i);
         prod2_p1_q <= mul(b_i, k2_i);
         off_p1_q   <= off_i;
         byp_p1_q   <= bypass_i;
         self_p1_q  <= self_i;
         // p2: sum, offset in output LSB units, rounding constant
         sum_p2_q   <= IW'(prod0_p1_q) + IW'(prod1_p1_q) + IW'(prod2_p1_q)
                     + (IW'(off_p1_q) <<< FRAC) + RND;
         byp_p2_q   <= byp_p1_q;
         self_p2_q  <= self_p1_q;
         // p3: shift, clamp, output register
         pix_p3_q   <= byp_p2_q ? self_p2_q : shift_clamp(sum_p2_q);
      end
   end

   assign pix_o = pix_p3_q;

endmodule

// File: rtl/ccm_matrix.sv
// Colour-correction matrix with double-buffered configuration that commits
// on the vsync rising edge, plus a 4-clock pixel and timing pipeline.
module ccm_matrix
   import ccm_matrix_pkg::*;
#(
   parameter int DW   = 8,
   parameter int CW   = 12,
   parameter int FRAC = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_vsync,
   input  logic          in_hsync,
   input  logic          in_den,
   input  logic [DW-1:0] in_data_R,
   input  logic [DW-1:0] in_data_G,
   input  logic [DW-1:0] in_data_B,
   input  logic          cfg_we,
   input  logic [3:0]    cfg_addr,
   input  logic [CW-1:0] cfg_wdata,
   output logic          cfg_pending,
   output logic          out_vsync,
   output logic          out_hsync,
   output logic          out_den,
   output logic [DW-1:0] out_data_R,
   output logic [DW-1:0] out_data_G,
   output logic [DW-1:0] out_data_B
);

   logic [CW-1:0] stg_q [NUM_CM];
   logic [CW-1:0] act_q [NUM_CM];
   logic          stg_byp_q, act_byp_q;
   logic          pend_q, pend_d;
   logic          we_cm, we_ctrl, commit;

   logic [2:0]    tim_p0_q, tim_p1_q, tim_p2_q, tim_p3_q;
   logic          vs_prev_q;
   logic [DW-1:0] r_p0_q, g_p0_q, b_p0_q;

   assign we_cm   = cfg_we && (cfg_addr < 4'(CTRL_ADDR));
   assign we_ctrl = cfg_we && (cfg_addr == 4'(CTRL_ADDR));
   assign commit  = tim_p0_q[2] && !vs_prev_q;

   // A write coinciding with a commit stays staged, so pending remains set.
   always_comb begin
      pend_d = pend_q;
      if (we_cm || we_ctrl)
         pend_d = 1'b1;
      else if (commit)
         pend_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_CM; i++) begin
            stg_q[i] <= CW'(ident_value(i, FRAC));
            act_q[i] <= CW'(ident_value(i, FRAC));
         end
         stg_byp_q <= 1'b0;
         act_byp_q <= 1'b0;
         pend_q    <= 1'b0;
      end else begin
         if (commit) begin
            act_q     <= stg_q;
            act_byp_q <= stg_byp_q;
         end
         if (we_cm)
            stg_q[cfg_addr] <= cfg_wdata;
         if (we_ctrl)
            stg_byp_q <= cfg_wdata[0];
         pend_q <= pend_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tim_p0_q  <= '0;
         tim_p1_q  <= '0;
         tim_p2_q  <= '0;
         tim_p3_q  <= '0;
         vs_prev_q <= 1'b0;
         r_p0_q    <= '0;
         g_p0_q    <= '0;
         b_p0_q    <= '0;
      end else begin
         // p0: input register
         tim_p0_q  <= {in_vsync, in_hsync, in_den};
         vs_prev_q <= tim_p0_q[2];
         r_p0_q    <= in_data_R;
         g_p0_q    <= in_data_G;
         b_p0_q    <= in_data_B;
         // p1..p3: timing follows the datapath inside the rows
         tim_p1_q  <= tim_p0_q;
         tim_p2_q  <= tim_p1_q;
         tim_p3_q  <= tim_p2_q;
      end
   end

   ccm_row #(.DW(DW), .CW(CW), .FRAC(FRAC)) u_row_r (
      .clk(clk), .reset(reset),
      .r_i(r_p0_q), .g_i(g_p0_q), .b_i(b_p0_q),
      .k0_i(act_q[COEF_BASE+0]), .k1_i(act_q[COEF_BASE+1]), .k2_i(act_q[COEF_BASE+2]),
      .off_i(act_q[OFFS_BASE+0]), .bypass_i(act_byp_q), .self_i(r_p0_q),
      .pix_o(out_data_R)
   );

   ccm_row #(.DW(DW), .CW(CW), .FRAC(FRAC)) u_row_g (
      .clk(clk), .reset(reset),
      .r_i(r_p0_q), .g_i(g_p0_q), .b_i(b_p0_q),
      .k0_i(act_q[COEF_BASE+3]), .k1_i(act_q[COEF_BASE+4]), .k2_i(act_q[COEF_BASE+5]),
      .off_i(act_q[OFFS_BASE+1]), .bypass_i(act_byp_q), .self_i(g_p0_q),
      .pix_o(out_data_G)
   );

   ccm_row #(.DW(DW), .CW(CW), .FRAC(FRAC)) u_row_b (
      .clk(clk), .reset(reset),
      .r_i(r_p0_q), .g_i(g_p0_q), .b_i(b_p0_q),
      .k0_i(act_q[COEF_BASE+6]), .k1_i(act_q[COEF_BASE+7]), .k2_i(act_q[COEF_BASE+8]),
      .off_i(act_q[OFFS_BASE+2]), .bypass_i(act_byp_q), .self_i(b_p0_q),
      .pix_o(out_data_B)
   );

   assign cfg_pending = pend_q;
   assign out_vsync   = tim_p3_q[2];
   assign out_hsync   = tim_p3_q[1];
   assign out_den     = tim_p3_q[0];

endmodule

// File: tb/tb_ccm_matrix.sv
// Bench for ccm_matrix: directed scenarios plus a randomized run checked
// against a frame-level model of staging, commit and matrix arithmetic.
module tb_ccm_matrix;

   localparam int DW   = 8;
   localparam int CW   = 12;
   localparam int FRAC = 8;
   localparam int ONE  = 1 << FRAC;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          in_vsync = 1'b0, in_hsync = 1'b0, in_den = 1'b0;
   logic [DW-1:0] in_data_R = '0, in_data_G = '0, in_data_B = '0;
   logic          cfg_we = 1'b0;
   logic [3:0]    cfg_addr = '0;
   logic [CW-1:0] cfg_wdata = '0;
   logic          cfg_pending;
   logic          out_vsync, out_hsync, out_den;
   logic [DW-1:0] out_data_R, out_data_G, out_data_B;

   ccm_matrix #(.DW(DW), .CW(CW), .FRAC(FRAC)) dut (
      .clk(clk), .reset(reset),
      .in_vsync(in_vsync), .in_hsync(in_hsync), .in_den(in_den),
      .in_data_R(in_data_R), .in_data_G(in_data_G), .in_data_B(in_data_B),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .cfg_pending(cfg_pending),
      .out_vsync(out_vsync), .out_hsync(out_hsync), .out_den(out_den),
      .out_data_R(out_data_R), .out_data_G(out_data_G), .out_data_B(out_data_B)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit vs, hs, de;
      int r, g, b;
   } exp_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   act[13];
   int   stg[13];
   bit   exp_pend;
   bit   prev_vs, rise_prev;
   exp_t pipe[$];
   exp_t exp_now;

   function automatic int sext(input int wd);
      int v;
      v = wd & ((1 << CW) - 1);
      if (v >= (1 << (CW - 1)))
         v = v - (1 << CW);
      return v;
   endfunction

   function automatic int ident(input int i);
      return (i == 0 || i == 4 || i == 8) ? ONE : 0;
   endfunction

   // Matrix row: exact sum, rounded to nearest by floor((s + ONE/2) / ONE), then clamped.
   function automatic int row_val(input int ka, kb, kc, o, r, g, b);
      int s, q;
      s = ka * r + kb * g + kc * b + o * ONE + ONE / 2;
      q = (s >= 0) ? s / ONE : -((-s + ONE - 1) / ONE);
      if (q < 0) q = 0;
      if (q > (1 << DW) - 1) q = (1 << DW) - 1;
      return q;
   endfunction

   // One clock: drive inputs, advance the model, then move to just after the edge.
   task automatic cyc(input bit rst, input bit vs, hs, de, input int r, g, b,
                      input bit we, input int addr, input int wd);
      exp_t e;
      bit   rise, ok;
      reset = rst; in_vsync = vs; in_hsync = hs; in_den = de;
      in_data_R = DW'(r); in_data_G = DW'(g); in_data_B = DW'(b);
      cfg_we = we; cfg_addr = 4'(addr); cfg_wdata = CW'(wd);
      if (rst) begin
         for (int i = 0; i < 13; i++) begin act[i] = ident(i); stg[i] = ident(i); end
         exp_pend = 0; prev_vs = 0; rise_prev = 0;
         e = '{default: 0};
         pipe.delete();
         for (int i = 0; i < 3; i++) pipe.push_back(e);
         exp_now = e;
      end else begin
         rise = vs && !prev_vs;
         if (rise_prev) act = stg;
         e.vs = vs; e.hs = hs; e.de = de;
         if (act[12] & 1) begin
            e.r = r; e.g = g; e.b = b;
         end else begin
            e.r = row_val(act[0], act[1], act[2], act[9],  r, g, b);
            e.g = row_val(act[3], act[4], act[5], act[10], r, g, b);
            e.b = row_val(act[6], act[7], act[8], act[11], r, g, b);
         end
         pipe.push_back(e);
         exp_now = pipe.pop_front();
         ok = we && (addr <= 12);
         if (ok) stg[addr] = sext(wd);
         exp_pend = ok ? 1'b1 : (rise_prev ? 1'b0 : exp_pend);
         rise_prev = rise;
         prev_vs = vs;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic wr(input int addr, input int wd);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, addr, wd);
   endtask

   task automatic commit_cfg();
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
   endtask

   task automatic load_cfg(input int m[13]);
      for (int i = 0; i < 13; i++) wr(i, m[i]);
      commit_cfg();
   endtask

   task automatic load_identity();
      int m[13];
      for (int i = 0; i < 13; i++) m[i] = ident(i);
      load_cfg(m);
   endtask

   // Send one pixel and stop exactly when it reaches the outputs.
   task automatic run_pixel(input int r, g, b);
      cyc(0, 0, 1, 1, r, g, b, 0, 0, 0);
      idle(3);
   endtask

   task automatic test_reset();
      cyc(1, 1, 1, 1, 9, 9, 9, 1, 0, 7);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if ({out_vsync, out_hsync, out_den, out_data_R, out_data_G, out_data_B, cfg_pending} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs got=%b/%b/%b %0d/%0d/%0d pend=%b required all zero",
                  out_vsync, out_hsync, out_den, out_data_R, out_data_G, out_data_B, cfg_pending);
      end
   endtask

   task automatic test_identity();
      cyc(0, 0, 1, 1, 100, 150, 200, 0, 0, 0);
      idle(2);
      n_cmp++;
      if (out_den !== 1'b0) begin
         n_bad++; $display("FAIL identity_early den got=%b required 0", out_den);
      end
      idle(1);
      n_cmp++;
      if ({out_den, out_hsync, out_vsync} !== 3'b110 || out_data_R !== 8'd100 ||
          out_data_G !== 8'd150 || out_data_B !== 8'd200) begin
         n_bad++;
         $display("FAIL identity den/hs/vs=%b%b%b rgb=%0d/%0d/%0d required 110 100/150/200",
                  out_den, out_hsync, out_vsync, out_data_R, out_data_G, out_data_B);
      end
   endtask

   task automatic test_saturation();
      int m[13];
      for (int i = 0; i < 13; i++) m[i] = ident(i);
      m[0] = 512;
      load_cfg(m);
      run_pixel(200, 0, 0);
      n_cmp++;
      if (out_data_R !== 8'd255 || out_data_G !== 8'd0 || out_data_B !== 8'd0) begin
         n_bad++;
         $display("FAIL saturation rgb=%0d/%0d/%0d required 255/0/0", out_data_R, out_data_G, out_data_B);
      end
   endtask

   task automatic test_neg_clamp();
      int m[13];
      for (int i = 0; i < 13; i++) m[i] = ident(i);
      m[0] = 256; m[1] = -256;
      load_cfg(m);
      run_pixel(10, 50, 0);
      n_cmp++;
      if (out_data_R !== 8'd0) begin
         n_bad++; $display("FAIL neg_clamp R=%0d required 0", out_data_R);
      end
      m[9] = 100;
      load_cfg(m);
      run_pixel(10, 50, 0);
      n_cmp++;
      if (out_data_R !== 8'd60 || out_data_G !== 8'd50) begin
         n_bad++; $display("FAIL offset R/G=%0d/%0d required 60/50", out_data_R, out_data_G);
      end
   endtask

   task automatic test_pending();
      load_identity();
      n_cmp++;
      if (cfg_pending !== 1'b0) begin
         n_bad++; $display("FAIL pending_idle got=%b required 0", cfg_pending);
      end
      cyc(0, 0, 1, 1, 20, 150, 30, 1, 4, 128);
      n_cmp++;
      if (cfg_pending !== 1'b1) begin
         n_bad++; $display("FAIL pending_set got=%b required 1", cfg_pending);
      end
      idle(3);
      run_pixel(20, 150, 30);
      n_cmp++;
      if (out_data_G !== 8'd150 || cfg_pending !== 1'b1) begin
         n_bad++; $display("FAIL pending_hold G=%0d pend=%b required 150/1", out_data_G, cfg_pending);
      end
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (cfg_pending !== 1'b1) begin
         n_bad++; $display("FAIL pending_rise got=%b required 1", cfg_pending);
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++;
      if (cfg_pending !== 1'b0) begin
         n_bad++; $display("FAIL pending_clear got=%b required 0", cfg_pending);
      end
      idle(2);
      run_pixel(20, 150, 30);
      n_cmp++;
      if (out_data_G !== 8'd75 || out_data_R !== 8'd20) begin
         n_bad++; $display("FAIL half_gain R/G=%0d/%0d required 20/75", out_data_R, out_data_G);
      end
   endtask

   task automatic test_bypass();
      int m[13];
      for (int i = 0; i < 13; i++) m[i] = 77 * i - 300;
      m[12] = 1;
      load_cfg(m);
      cyc(0, 0, 1, 1, 17, 34, 51, 0, 0, 0);
      idle(2);
      n_cmp++;
      if (out_den !== 1'b0) begin
         n_bad++; $display("FAIL bypass_early den got=%b required 0", out_den);
      end
      idle(1);
      n_cmp++;
      if (out_den !== 1'b1 || out_data_R !== 8'd17 || out_data_G !== 8'd34 || out_data_B !== 8'd51) begin
         n_bad++;
         $display("FAIL bypass den=%b rgb=%0d/%0d/%0d required 1 17/34/51",
                  out_den, out_data_R, out_data_G, out_data_B);
      end
   endtask

   task automatic test_same_cycle();
      load_identity();
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 512);
      n_cmp++;
      if (cfg_pending !== 1'b1) begin
         n_bad++; $display("FAIL same_cycle_pending got=%b required 1", cfg_pending);
      end
      idle(2);
      run_pixel(100, 0, 0);
      n_cmp++;
      if (out_data_R !== 8'd100 || cfg_pending !== 1'b1) begin
         n_bad++; $display("FAIL same_cycle_old R=%0d pend=%b required 100/1", out_data_R, cfg_pending);
      end
      commit_cfg();
      run_pixel(100, 0, 0);
      n_cmp++;
      if (out_data_R !== 8'd200 || cfg_pending !== 1'b0) begin
         n_bad++; $display("FAIL same_cycle_new R=%0d pend=%b required 200/0", out_data_R, cfg_pending);
      end
   endtask

   task automatic test_reset_midframe();
      wr(0, 512);
      wr(12, 1);
      cyc(0, 0, 1, 1, 90, 91, 92, 0, 0, 0);
      cyc(0, 0, 1, 1, 93, 94, 95, 0, 0, 0);
      cyc(1, 0, 1, 1, 96, 97, 98, 0, 0, 0);
      n_cmp++;
      if ({out_den, out_data_R, out_data_G, out_data_B, cfg_pending} !== '0) begin
         n_bad++;
         $display("FAIL midframe_reset den=%b rgb=%0d/%0d/%0d pend=%b required zero",
                  out_den, out_data_R, out_data_G, out_data_B, cfg_pending);
      end
      idle(3);
      n_cmp++;
      if (out_den !== 1'b0) begin
         n_bad++; $display("FAIL midframe_flush den=%b required 0", out_den);
      end
      run_pixel(100, 150, 200);
      n_cmp++;
      if (out_den !== 1'b1 || out_data_R !== 8'd100 || out_data_G !== 8'd150 || out_data_B !== 8'd200) begin
         n_bad++;
         $display("FAIL post_reset den=%b rgb=%0d/%0d/%0d required 1 100/150/200",
                  out_den, out_data_R, out_data_G, out_data_B);
      end
      commit_cfg();
      run_pixel(100, 150, 200);
      n_cmp++;
      if (out_data_R !== 8'd100 || out_data_G !== 8'd150) begin
         n_bad++; $display("FAIL staged_dropped R/G=%0d/%0d required 100/150", out_data_R, out_data_G);
      end
   endtask

   task automatic test_back_to_back_random();
      int addr, wd;
      bit we, vs;
      for (int i = 0; i < 600; i++) begin
         vs = (i % 37) < 2;
         we = ($urandom_range(0, 5) == 0);
         addr = $urandom_range(0, 15);
         if (addr < 9)       wd = $urandom_range(0, 700) - 350;
         else if (addr < 12) wd = $urandom_range(0, 160) - 80;
         else                wd = ($urandom_range(0, 5) == 0) ? 1 : 0;
         cyc(0, vs, $urandom_range(0, 1), $urandom_range(0, 3) != 0,
             $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), we, addr, wd);
         n_cmp++;
         if ({out_vsync, out_hsync, out_den, cfg_pending} !== {exp_now.vs, exp_now.hs, exp_now.de, exp_pend}) begin
            n_bad++;
            $display("FAIL rand_ctrl i=%0d vs/hs/de/pend got=%b%b%b%b required %b%b%b%b", i,
                     out_vsync, out_hsync, out_den, cfg_pending, exp_now.vs, exp_now.hs, exp_now.de, exp_pend);
         end
         if (exp_now.de) begin
            n_cmp++;
            if (out_data_R !== DW'(exp_now.r) || out_data_G !== DW'(exp_now.g) || out_data_B !== DW'(exp_now.b)) begin
               n_bad++;
               $display("FAIL rand_pixel i=%0d got=%0d/%0d/%0d required %0d/%0d/%0d", i,
                        out_data_R, out_data_G, out_data_B, exp_now.r, exp_now.g, exp_now.b);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_saturation();
      test_neg_clamp();
      test_pending();
      test_bypass();
      test_same_cycle();
      test_reset_midframe();
      test_back_to_back_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ccm_matrix.md
CCM_MATRIX -- requirements
Module: ccm_matrix

Interface
REQ-001 SHALL have parameter DW, default 8, meaning per-channel pixel width.
REQ-002 SHALL have parameter CW, default 12, meaning signed coefficient width.
REQ-003 SHALL have parameter FRAC, default 8, meaning coefficient fractional bits (1.0 = 2^FRAC).
REQ-004 SHALL have ports:
  clk  input  1  pixel/config clock
  reset  input  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
  in_vsync/in_hsync/in_den  input  1 each  input timing
  in_data_R/G/B  input  DW each  input pixel
  cfg_we  input  1  config write strobe
  cfg_addr  input  4  config register index
  cfg_wdata  input  CW  config write data
  cfg_pending  output  1  staged config not yet committed
  out_vsync/out_hsync/out_den  output  1 each  delayed timing
  out_data_R/G/B  output  DW each  corrected pixel

Function
REQ-005 SHALL compute R'=c0*R+c1*G+c2*B+o0, G'=c3*R+c4*G+c5*B+o1, B'=c6*R+c7*G+c8*B+o2, then shift right FRAC and clamp.
REQ-006 SHALL treat c0..c8 as signed CW-bit, pixels as unsigned DW-bit, offsets o0..o2 as signed CW-bit in output LSB units (scaled by 2^FRAC before summing).
REQ-007 SHALL add rounding constant 2^(FRAC-1) before arithmetic right shift by FRAC; intermediate width DW+CW+3 bits signed, no overflow.
REQ-008 SHALL clamp results <0 to 0 and >2^DW-1 to 2^DW-1.
REQ-009 SHALL have fixed latency 4 clocks: input register, 9 products, sum+offset+round, clamp/output register.
REQ-010 SHALL delay vsync/hsync/den by exactly 4 clocks, aligned with data; no stalls, one pixel per clock.
REQ-011 SHALL map cfg_addr 0..8 to c0..c8, 9..11 to o0..o2, 12 to control (bit0 = bypass); writes to 13..15 ignored.
REQ-012 SHALL write cfg_wdata to a staging register set on cfg_we; active set unchanged.
REQ-013 SHALL commit whole staging set to active set in the cycle after an in_vsync rising edge (0->1 at input register stage).
REQ-014 SHALL, on same-cycle write and commit, commit the pre-write staging value; the new write stays staged and cfg_pending remains 1.
REQ-015 SHALL drive cfg_pending 1 from the cycle after any accepted write until the cycle after commit (unless REQ-014 applies).
REQ-016 SHALL, when active bypass=1, output the delayed input pixel unchanged, still with 4-clock latency.
REQ-017 SHALL pass data through the arithmetic path regardless of den; output data when den=0 is don't-care but deterministic.

Reset
REQ-018 SHALL on reset clear all pipeline stages and outputs (out_* = 0, cfg_pending = 0).
REQ-019 SHALL on reset load staging and active sets with identity: c0=c4=c8=2^FRAC, other coefficients 0, offsets 0, bypass 0.
REQ-020 SHALL abandon in-flight pixels and staged writes on reset mid-frame; first valid output 4 clocks after first post-reset den.

Structure
REQ-021 SHALL place register index constants (COEF base 0, OFFS base 9, CTRL 12) and default identity value in a shared isp package.
REQ-022 SHALL implement one sub-module ccm_row (three multiplies, sum, offset, round, clamp), instantiated three times.

Verification
REQ-023 Identity default, input R/G/B=100/150/200 with den=1 -> output 100/150/200 exactly 4 clocks later, sync aligned.
REQ-024 Stage c0=512 (2.0), commit via vsync, R=200,G=B=0 -> out R=255 (saturation), G=B=0.
REQ-025 Stage c0=256,c1=-256, R=10,G=50 -> out R=0 (negative clamp); with o0=100 -> out R=60.
REQ-026 Write c4=128 mid-frame -> G unchanged and cfg_pending=1 until vsync rise; afterward G=150 -> 75.
REQ-027 Set bypass=1 with non-identity matrix, input 17/34/51 -> output 17/34/51 at 4-clock latency.
REQ-028 Assert reset mid-frame with staged writes -> outputs 0 next clock, cfg_pending=0, identity behaviour resumes after release.
